// File: rtl/registers_file.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous write port, r0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward write_data to a matching read port before the clock edge.
module registers_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  w_write_ok;
  logic [DATA_WIDTH-1:0] w_stored1;
  logic [DATA_WIDTH-1:0] w_stored2;

  assign w_write_ok = write_enable && (write_reg != '0);

  // Reset clears every entry immediately; writes to r0 are dropped so it never holds data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_write_ok) begin
      r_regs[write_reg] <= write_data;
    end
  end

  assign w_stored1 = (read_reg1 == '0) ? '0 : r_regs[read_reg1];
  assign w_stored2 = (read_reg2 == '0) ? '0 : r_regs[read_reg2];

`ifdef REGFILE_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;

  // Forwarding is blocked during reset so reads still see the cleared array.
  assign w_fwd1 = !rst && w_write_ok && (read_reg1 == write_reg);
  assign w_fwd2 = !rst && w_write_ok && (read_reg2 == write_reg);

  assign read_data1 = w_fwd1 ? write_data : w_stored1;
  assign read_data2 = w_fwd2 ? write_data : w_stored2;
`else
  assign read_data1 = w_stored1;
  assign read_data2 = w_stored2;
`endif

endmodule

// File: tb/tb_registers_file.sv
// Self-checking bench for registers_file: each check samples the read ports directly and compares them against the expected values.
module tb_registers_file;

`ifdef REGFILE_BYPASS_EN
   localparam bit Bypass = 1'b1;
`else
   localparam bit Bypass = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        writeEnable;
   logic [4:0]  readReg1;
   logic [4:0]  readReg2;
   logic [4:0]  writeReg;
   logic [31:0] writeData;
   logic [31:0] readData1;
   logic [31:0] readData2;

   int checks = 0;
   int errors = 0;

   registers_file dut (
      .clk          (clk),
      .rst          (rst),
      .write_enable (writeEnable),
      .read_reg1    (readReg1),
      .read_reg2    (readReg2),
      .write_reg    (writeReg),
      .write_data   (writeData),
      .read_data1   (readData1),
      .read_data2   (readData2)
   );

   // Free-running clock with a 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive every DUT input in one call so each scenario is set up atomically.
   task automatic applyStimulus(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                                input logic [4:0] r1, input logic [4:0] r2);
      writeEnable = we;
      writeReg    = wr;
      writeData   = wd;
      readReg1    = r1;
      readReg2    = r2;
   endtask

   // Let the combinational read path settle, compare both ports, then hold before inputs move again.
   task automatic checkOutput(input string name, input logic [31:0] e1, input logic [31:0] e2);
      #1;
      checks++;
      if (readData1 !== e1 || readData2 !== e2) begin
         errors++;
         $display("[TB] FAIL %s: got rd1=%h rd2=%h, expected rd1=%h rd2=%h",
                  name, readData1, readData2, e1, e2);
      end
      #1;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Abort if the stimulus never reaches its end.
   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] timeout");
   end

   // Main scenario sequence following the test plan.
   initial begin : stimulus
      rst = 1'b1;
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
      #3;
      checkOutput("reset_r5_r31", 32'h0, 32'h0);
      for (int i = 0; i < 32; i++) begin
         readReg1 = 5'(i);
         readReg2 = 5'(31 - i);
         checkOutput($sformatf("reset_all_%0d", i), 32'h0, 32'h0);
         checks++;
         if (readData1 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_sweep_%0d: rd1=%h", i, readData1);
         end
      end

      applyStimulus(1'b1, 5'd9, 32'hAAAA_5555, 5'd9, 5'd9);
      checkOutput("reset_write_pre", 32'h0, 32'h0);
      tick();
      checkOutput("reset_write_post", 32'h0, 32'h0);
      checks++;
      if (readData2 !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_write_direct: rd2=%h", readData2);
      end
      @(negedge clk);
      writeEnable = 1'b0;
      rst = 1'b0;
      #1;
      checkOutput("after_release", 32'h0, 32'h0);

      @(negedge clk);
      applyStimulus(1'b1, 5'd20, 32'd10, 5'd20, 5'd0);
      checkOutput("basic_pre_edge", Bypass ? 32'd10 : 32'd0, 32'h0);
      tick();
      checkOutput("basic_post_edge", 32'd10, 32'h0);
      applyStimulus(1'b0, 5'd20, 32'd120, 5'd20, 5'd0);
      checkOutput("we_low_pre", 32'd10, 32'h0);
      tick();
      checkOutput("we_low_post", 32'd10, 32'h0);

      @(negedge clk);
      applyStimulus(1'b1, 5'd1, 32'd120, 5'd20, 5'd1);
      checkOutput("same_cycle_pre", 32'd10, Bypass ? 32'd120 : 32'd0);
      tick();
      checkOutput("same_cycle_post", 32'd10, 32'd120);
      checks++;
      if (readData2 !== 32'd120) begin
         errors++;
         $display("[TB] FAIL same_cycle_direct: rd2=%h", readData2);
      end

      @(negedge clk);
      applyStimulus(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
      checkOutput("r0_pre", 32'h0, 32'h0);
      tick();
      checkOutput("r0_post", 32'h0, 32'h0);
      checks++;
      if (readData1 !== 32'h0) begin
         errors++;
         $display("[TB] FAIL r0_direct: rd1=%h", readData1);
      end

      applyStimulus(1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd1);
      tick();
      checkOutput("r31_write", 32'hFFFF_FFFF, 32'd120);

      applyStimulus(1'b1, 5'd7, 32'h1234, 5'd7, 5'd20);
      tick();
      checkOutput("r7_written", 32'h1234, 32'd10);
      writeEnable = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      checkOutput("async_reset_clears", 32'h0, 32'h0);
      checks++;
      if (readData1 !== 32'h0) begin
         errors++;
         $display("[TB] FAIL async_reset_direct: rd1=%h", readData1);
      end
      applyStimulus(1'b1, 5'd7, 32'h5555, 5'd7, 5'd1);
      checkOutput("reset_blocks_fwd", 32'h0, 32'h0);
      tick();
      checkOutput("reset_blocks_write", 32'h0, 32'h0);
      @(negedge clk);
      writeEnable = 1'b0;
      rst = 1'b0;
      tick();
      checkOutput("post_reset_r7_r1", 32'h0, 32'h0);
      readReg1 = 5'd20;
      readReg2 = 5'd31;
      checkOutput("post_reset_r20_r31", 32'h0, 32'h0);

      applyStimulus(1'b1, 5'd3, 32'd3, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b1, 5'd4, 32'd4, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
      checkOutput("dual_port", 32'd3, 32'd4);
      applyStimulus(1'b0, 5'd3, 32'd99, 5'd3, 5'd4);
      tick();
      checkOutput("gated_write", 32'd3, 32'd4);
      checks++;
      if (readData1 !== 32'd3) begin
         errors++;
         $display("[TB] FAIL gated_write_direct: rd1=%h", readData1);
      end
      readReg2 = 5'd3;
      checkOutput("same_index", 32'd3, 32'd3);

      #5;
      $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
      if (errors == 0)
         $display("[TB] PASS");
      else
         $display("[TB] FAIL");
      $finish;
   end

endmodule

// File: doc/registers_file.md
Name: registers_file

Overview:
- 32-entry x 32-bit general-purpose register file for the Phase1 MIPS-style datapath.
- Two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Feeds the ALU operand paths and accepts write-back results.

Parameters:
- DATA_WIDTH, 32: width of each register and of the data ports.
- ADDR_WIDTH, 5: width of the register-index ports.
- NUM_REGS, 32: number of registers; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- write_enable  input  1  when high, write_data is stored into write_reg at the rising edge of clk.
- read_reg1  input  ADDR_WIDTH  index for read port 1.
- read_reg2  input  ADDR_WIDTH  index for read port 2.
- write_reg  input  ADDR_WIDTH  index for the write port.
- write_data  input  DATA_WIDTH  data to be written.
- read_data1  output  DATA_WIDTH  contents of register read_reg1.
- read_data2  output  DATA_WIDTH  contents of register read_reg2.

Behaviour:
- Reset:
  - rst high immediately clears all registers to 0, independent of clk.
  - read_data1 and read_data2 therefore read 0 while rst is high and after it is released, until the next write.
  - A write_enable pulse coincident with an active rst is ignored.
  - Deasserting rst mid-cycle has no effect until the next rising edge.
- Write:
  - On the rising edge of clk with rst low and write_enable high, reg[write_reg] <= write_data.
  - With write_enable low, no register changes.
  - Write latency is 1 edge: the new value is visible on the read ports after that edge.
- Register 0:
  - Writes to index 0 are discarded.
  - Reads of index 0 always return 0.
- Read:
  - Purely combinational, asynchronous: read_data = reg[read_reg].
  - Output updates in the same delta whenever read_reg or the stored contents change.
  - No clock or enable on the read path.
- Same index on both read ports: both outputs carry the same value.
- Read of a register being written in the same cycle:
  - Without the optional feature, returns the old stored value until the edge, then the new value.
- X/Z on write_data with write_enable high stores X; nothing is sanitised.
- No other state; no handshake; always ready.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined: write-through forwarding. If write_enable is high, write_reg is nonzero and read_regN equals write_reg, then read_dataN = write_data combinationally, before the clock edge. This lets a write-back and a read in the same cycle resolve without a hazard.
- When undefined: reads always return the stored array contents; no forwarding logic is synthesised.
- Reset and register-0 rules apply in both builds. Forwarding is suppressed while rst is high.

Test Plan:
- Reset: assert rst, then set read_reg1=5, read_reg2=31 -> read_data1=0, read_data2=0; all 32 registers read 0.
- Basic write/read: write_reg=20, write_data=10, write_enable=1, rising edge; then write_enable=0, write_data=120, read_reg1=20, edge -> read_data1=10 (120 not stored).
- Same-cycle write/read (no bypass): write_enable=1, write_reg=1, write_data=120, read_reg2=1 -> read_data2=0 before the edge, 120 after it. With REGFILE_BYPASS_EN: 120 immediately, before the edge.
- Register 0: write_reg=0, write_data=32'hDEADBEEF, write_enable=1, edge; read_reg1=0 -> read_data1=0.
- Async reset mid-operation: after writing reg7=32'h1234, pulse rst high between clock edges -> read_data of reg7 becomes 0 immediately, without a clock edge; a write attempted while rst is high is ignored.
- Dual-port and write_enable gating: write reg3=3 and reg4=4; read_reg1=3, read_reg2=4 -> 3 and 4. Then write_enable=0, write_reg=3, write_data=99, edge -> read_data1 stays 3.
